pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline-stage register with valid/ready handshake, a one-entry skid buffer, flush, and bubble masking of control bits. It replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the pipelined datapath. Each instance carries one control bundle and one data bundle, with widths set per stage. It sustains one transfer per cycle under back-pressure, and its `in_ready` has no combinational path from `out_ready`.

## Interface
- `CTRL_WIDTH`, default 9: control bundle width (aluop, alusrc, memWrite, memRead, mem2Reg, regWrite, …); zeroed in bubbles.
- `DATA_WIDTH`, default 64: data word width.
- `NUM_WORDS`, default 4: number of data words in the payload (PC, ReadData1, ReadData2, signExtended, …).
- `TAG_WIDTH`, default 21: side-band tag (aluCtrl, Rm, Rd, …); held, never masked.
- Port list:
  - `clock` in 1: sole clock, rising edge.
  - `reset` in 1: synchronous, active-low reset.
  - `flush` in 1: kill all held entries and the incoming beat at this edge.
  - `in_valid` in 1: upstream beat present.
  - `in_ready` out 1: stage accepts a beat this cycle.
  - `in_ctrl` in CTRL_WIDTH: control bundle.
  - `in_data` in NUM_WORDS*DATA_WIDTH: data words; word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
  - `in_tag` in TAG_WIDTH: tag.
  - `out_valid` out 1: beat presented downstream.
  - `out_ready` in 1: downstream accepts.
  - `out_ctrl` out CTRL_WIDTH: control; all-zero whenever `out_valid`=0.
  - `out_data` out NUM_WORDS*DATA_WIDTH: data.
  - `out_tag` out TAG_WIDTH: tag.
  - `occupancy` out 2: number of held entries, 0–2.

## Operation
- Storage consists of a main register, which drives the outputs, and a skid register. Each has a valid bit.
- Handshake signals:
  - in_fire = `in_valid` & `in_ready`.
  - out_fire = `out_valid` & `out_ready`.
  - `in_ready` = !skid_valid.
  - `out_valid` = main_valid.
- States: EMPTY (0 held), BUSY (main only), FULL (main + skid).
- EMPTY:
  - in_fire: main <= in; go to BUSY.
- BUSY:
  - in_fire & out_fire: main <= in; stay in BUSY.
  - in_fire & !out_fire: skid <= in; go to FULL.
  - !in_fire & out_fire: go to EMPTY.
  - Neither: hold.
- FULL (`in_ready`=0):
  - out_fire: main <= skid; go to BUSY.
  - Otherwise hold.
- `flush`=1 takes priority over every transition:
  - Next state is EMPTY and both valids clear.
  - The input beat at that edge is dropped, even if `in_valid`=1.
  - A beat on the outputs with `out_ready`=1 in the flush cycle counts as consumed; the flush does not retract it.
- `reset`=0 takes priority over `flush` and clears everything. After reset:
  - valids = 0, so `out_valid` = 0, `in_ready` = 1, `occupancy` = 0.
  - `out_ctrl` = 0, `out_data` = 0, `out_tag` = 0.
- Bubble masking: `out_ctrl` = main_ctrl & {CTRL_WIDTH{main_valid}}, so a bubble never asserts regWrite or memWrite. `out_data` and `out_tag` keep their last value when invalid. Flush does not clear them.
- Data, tag and control pass through unmodified; there is no arithmetic.
- Order is preserved: the skid entry always follows the main entry.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is on the outputs with `out_valid`=1 after edge N.
- Throughput is 1 beat per cycle while `out_ready`=1.
- A single `out_ready`=0 cycle costs no bubble: the skid absorbs the beat in flight.
- `in_ready`, `out_valid` and `occupancy` are registered-state functions only. No combinational path runs from `flush`, `in_valid` or `out_ready` to any output.
- `out_ctrl` passes through one AND gate after the register.
- Boundary cases:
  - FULL with `in_valid`=1: the beat is not taken, and upstream must hold it.
  - FULL with out_fire and `in_valid`=1 in the same cycle: `in_ready` is already 0, so only the drain happens.
  - EMPTY with out_ready toggling: no effect.
- Reset or flush mid-burst: beats held in main or skid are lost. The first beat after release is accepted in the first cycle with `reset`=1 and `flush`=0.

## Test plan
- Reset, then stream ctrl=0x1FF, data words = k+1, tag = i for 8 beats with `out_ready`=1:
  - Outputs match one cycle later, one per cycle.
  - `occupancy` stays at 1.
  - `in_ready` stays 1.
- Stream with `out_ready` low for one cycle at beat 3:
  - `occupancy` goes 1→2→1.
  - `in_ready` is 0 for exactly one cycle.
  - No beat is lost or duplicated, and order is preserved.
- Hold `out_ready`=0 for 5 cycles with `in_valid`=1:
  - Exactly 2 beats are accepted and `in_ready`=0 thereafter.
  - On release the beats drain in order, with `out_valid`=1 for 2 consecutive cycles before the next upstream beat appears.
- `flush`=1 while FULL and `in_valid`=1:
  - Next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0, `in_ready`=1.
  - The dropped input never appears.
- `reset`=0 asserted while FULL together with `flush`:
  - Next cycle all outputs are 0.
  - With `reset`=1 the first beat is accepted immediately.
- Idle after one beat has drained:
  - `out_valid`=0 and `out_ctrl`=0.
  - `out_data` and `out_tag` still show the last beat's values.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with a one-entry skid buffer,
// flush, and control-bit masking on bubbles.
module pipe_stage_reg #(
  parameter int CTRL_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 4,
  parameter int TAG_WIDTH  = 21
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [CTRL_WIDTH-1:0]           in_ctrl,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] in_data,
  input  logic [TAG_WIDTH-1:0]            in_tag,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CTRL_WIDTH-1:0]           out_ctrl,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]            out_tag,
  output logic [1:0]                      occupancy
);
  localparam int PW = CTRL_WIDTH + NUM_WORDS*DATA_WIDTH + TAG_WIDTH;
  logic [PW-1:0] main_q, main_d, skid_q, skid_d, in_pl;
  logic [CTRL_WIDTH-1:0] main_ctrl;
  logic main_v_q, main_v_d, skid_v_q, skid_v_d, in_fire, out_fire, take;
  assign in_pl = {in_ctrl, in_data, in_tag};
  assign in_ready = !skid_v_q;
  assign out_valid = main_v_q;
  assign occupancy = {skid_v_q, main_v_q & !skid_v_q};
  assign {main_ctrl, out_data, out_tag} = main_q;
  assign out_ctrl = main_ctrl & {CTRL_WIDTH{main_v_q}};
  always_comb begin
    in_fire = in_valid & !skid_v_q;
    out_fire = main_v_q & out_ready;
    take = in_fire & !flush;
    // payload registers are never written on a flush so the last beat stays visible
    main_d = !flush & skid_v_q & out_fire ? skid_q
           : take & (!main_v_q | out_fire) ? in_pl : main_q;
    skid_d = take & main_v_q & !out_fire ? in_pl : skid_q;
    main_v_d = !flush & (skid_v_q | in_fire | (main_v_q & !out_fire));
    skid_v_d = !flush & (skid_v_q ? !out_fire : in_fire & main_v_q & !out_fire);
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end
endmodule
